// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Sequencing controller for the 5-stage pipeline registers. Resolves the
//   hazards forwarding cannot: load-use bubbles, wrong-path squash on taken
//   branches, and whole-pipeline freeze while data memory is busy.
//   Outputs are Mealy (combinational from state + inputs).
//   Optional build macro HAZARD_PERF_CNT_EN adds stall/flush perf counters.
module pipeline_hazard_controller #(
   parameter int LOAD_USE_STALLS = 1,    // bubbles per load-use hazard (1..7)
   parameter int MEM_TIMEOUT     = 255   // freeze cycles before mem_timeout (1..255)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  if_id_rs1,
   input  logic [4:0]  if_id_rs2,
   input  logic        if_id_uses_rs2,
   input  logic [4:0]  id_ex_rd,
   input  logic        id_ex_memread,
   input  logic        ex_branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        pipe_adv,
   output logic        stall_active,
   output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flushes
`endif
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] LU_STALL = 2'd1;
   localparam logic [1:0] MEM_WAIT = 2'd2;

   // LU_STALL is entered holding the number of bubbles still to come.
   localparam logic [2:0] LU_RELOAD   = 3'(LOAD_USE_STALLS - 1);
   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   logic [1:0] state, state_nxt;
   logic [1:0] eff_state;
   logic       saved_lu, saved_lu_nxt;   // state before the freeze was LU_STALL
   logic [2:0] stall_cnt, stall_cnt_nxt;
   logic [7:0] wait_cnt, wait_inc;
   logic       timeout_q;

   logic       freeze;
   logic       lu;
   logic       branch_flush;

   assign freeze = mem_req & ~mem_ready;

   assign lu = id_ex_memread & (id_ex_rd != 5'd0) &
               ((id_ex_rd == if_id_rs1) |
                (if_id_uses_rs2 & (id_ex_rd == if_id_rs2)));

   // The release cycle of a freeze behaves exactly as the state that was
   // interrupted; stall_cnt is simply held through the wait, so only the
   // state needs remembering.
   assign eff_state = (state == MEM_WAIT) ? (saved_lu ? LU_STALL : RUN) :
                      (state == LU_STALL) ? LU_STALL : RUN;

   assign wait_inc = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

   assign branch_flush = ~freeze & ex_branch_taken;

   // Output decode and next-state selection, priority freeze > branch > load-use.
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      pipe_adv      = 1'b1;
      state_nxt     = RUN;
      stall_cnt_nxt = stall_cnt;
      saved_lu_nxt  = saved_lu;

      if (freeze) begin
         // Everything holds; no flushes so nothing in flight is lost.
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_adv    = 1'b0;
         state_nxt   = MEM_WAIT;
         if (state != MEM_WAIT)
            saved_lu_nxt = (state == LU_STALL);
      end else if (ex_branch_taken) begin
         // Squash both wrong-path slots; any pending load-use bubble dies
         // with the dependent instruction.
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         state_nxt     = RUN;
         stall_cnt_nxt = 3'd0;
      end else if (eff_state == LU_STALL) begin
         // Bubble countdown; lu is deliberately not re-evaluated here.
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
         if (stall_cnt <= 3'd1) begin
            state_nxt     = RUN;
            stall_cnt_nxt = 3'd0;
         end else begin
            state_nxt     = LU_STALL;
            stall_cnt_nxt = stall_cnt - 3'd1;
         end
      end else if (lu) begin
         // First bubble; older instructions keep draining.
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
         if (LOAD_USE_STALLS > 1) begin
            state_nxt     = LU_STALL;
            stall_cnt_nxt = LU_RELOAD;
         end else begin
            state_nxt     = RUN;
            stall_cnt_nxt = 3'd0;
         end
      end

      if (!rst_n) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_adv    = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end
   end

   assign stall_active = ~pc_write | ~rst_n;
   assign mem_timeout  = timeout_q;

   // State, stall/wait counters and the sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RUN;
         saved_lu  <= 1'b0;
         stall_cnt <= 3'd0;
         wait_cnt  <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         saved_lu  <= saved_lu_nxt;
         stall_cnt <= stall_cnt_nxt;
         if (freeze) begin
            wait_cnt <= wait_inc;
            if (wait_inc >= TIMEOUT_CNT)
               timeout_q <= 1'b1;
         end else begin
            wait_cnt <= 8'd0;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating counters of stalled cycles and branch squash events.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_stall_cycles <= 32'd0;
         perf_flushes      <= 32'd0;
      end else begin
         if (stall_active && perf_stall_cycles != 32'hFFFF_FFFF)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (branch_flush && perf_flushes != 32'hFFFF_FFFF)
            perf_flushes <= perf_flushes + 32'd1;
      end
   end
`else
   logic unused_ok;
   assign unused_ok = branch_flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances share stimulus,
// A with default parameters, B with LOAD_USE_STALLS=3, MEM_TIMEOUT=10.
// Vectors are table rows; expected outputs go through a scoreboard queue.
module tb_pipeline_hazard_controller;

   logic       clk;
   logic       rst_n;
   logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
   logic       if_id_uses_rs2, id_ex_memread, ex_branch_taken, mem_req, mem_ready;

   logic pc_write_a, if_id_write_a, if_id_flush_a, id_ex_flush_a, pipe_adv_a, stall_active_a, mem_timeout_a;
   logic pc_write_b, if_id_write_b, if_id_flush_b, id_ex_flush_b, pipe_adv_b, stall_active_b, mem_timeout_b;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cycles_a, perf_flushes_a, perf_stall_cycles_b, perf_flushes_b;
`endif

   pipeline_hazard_controller dut_a (
      .clk(clk), .rst_n(rst_n),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
      .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a),
      .id_ex_flush(id_ex_flush_a), .pipe_adv(pipe_adv_a), .stall_active(stall_active_a),
      .mem_timeout(mem_timeout_a)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cycles(perf_stall_cycles_a), .perf_flushes(perf_flushes_a)
`endif
   );

   pipeline_hazard_controller #(.LOAD_USE_STALLS(3), .MEM_TIMEOUT(10)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
      .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b),
      .id_ex_flush(id_ex_flush_b), .pipe_adv(pipe_adv_b), .stall_active(stall_active_b),
      .mem_timeout(mem_timeout_b)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cycles(perf_stall_cycles_b), .perf_flushes(perf_flushes_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_adv, stall_active}
   localparam logic [5:0] O_RUN = 6'b110010;
   localparam logic [5:0] O_LU  = 6'b000111;
   localparam logic [5:0] O_BR  = 6'b111110;
   localparam logic [5:0] O_FRZ = 6'b000001;
   localparam logic [5:0] O_RST = 6'b001101;

   typedef struct {
      string      nm;
      logic       r;
      logic [4:0] rs1, rs2, rd;
      logic       uses, memread, br, mreq, mrdy;
      logic [5:0] ea, eb;
      logic       ta, tb;
   } vec_t;

   typedef struct {
      string      nm;
      int         idx;
      logic [5:0] ea, eb;
      logic       ta, tb;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic add(input string nm, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                      input logic [4:0] rd, input logic memread, input logic br,
                      input logic mreq, input logic mrdy,
                      input logic [5:0] ea, input logic [5:0] eb,
                      input logic ta, input logic tb);
      vec_t v;
      v.nm = nm; v.r = r; v.rs1 = rs1; v.rs2 = rs2; v.uses = uses; v.rd = rd;
      v.memread = memread; v.br = br; v.mreq = mreq; v.mrdy = mrdy;
      v.ea = ea; v.eb = eb; v.ta = ta; v.tb = tb;
      tbl.push_back(v);
   endtask

   // Idle / common stimulus shorthands.
   task automatic idle(input string nm, input logic [5:0] ea, input logic [5:0] eb,
                       input logic ta, input logic tb);
      add(nm, 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, ta, tb);
   endtask

   task automatic frz(input string nm, input logic br, input logic mrdy,
                      input logic [5:0] ea, input logic [5:0] eb,
                      input logic ta, input logic tb);
      add(nm, 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, br, 1'b1, mrdy, ea, eb, ta, tb);
   endtask

   task automatic check(input string nm, input int idx, input logic [6:0] act, input logic [6:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s row %0d: got %b required %b", nm, idx, act, req);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      // Default parameters: single bubble; B: three bubbles.
      add("reset", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST, O_RST, 1'b0, 1'b0);
      idle("idle0", O_RUN, O_RUN, 0, 0);
      add("lu_rs1", 1'b1, 5'd5, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, O_LU, 0, 0);
      idle("lu_rs1_b2", O_RUN, O_LU, 0, 0);
      idle("lu_rs1_b3", O_RUN, O_LU, 0, 0);
      idle("lu_done", O_RUN, O_RUN, 0, 0);
      add("lu_rd0", 1'b1, 5'd0, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN, O_RUN, 0, 0);
      add("lu_rs2", 1'b1, 5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, O_LU, 0, 0);
      idle("lu_rs2_b2", O_RUN, O_LU, 0, 0);
      idle("lu_rs2_b3", O_RUN, O_LU, 0, 0);
      add("lu_rs2_unused", 1'b1, 5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN, O_RUN, 0, 0);
      // Branch in the second stall cycle of B cancels the remaining bubble.
      add("lu_pre_br", 1'b1, 5'd5, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, O_LU, 0, 0);
      add("br_in_stall", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR, O_BR, 0, 0);
      idle("after_br", O_RUN, O_RUN, 0, 0);
      // Four-cycle freeze then release.
      for (int k = 0; k < 4; k++) frz("freeze4", 1'b0, 1'b0, O_FRZ, O_FRZ, 0, 0);
      frz("release", 1'b0, 1'b1, O_RUN, O_RUN, 0, 0);
      // Branch held through a freeze flushes only in the release cycle.
      for (int k = 0; k < 3; k++) frz("freeze_br", 1'b1, 1'b0, O_FRZ, O_FRZ, 0, 0);
      frz("release_br", 1'b1, 1'b1, O_BR, O_BR, 0, 0);
      idle("after_rel_br", O_RUN, O_RUN, 0, 0);
      // Freeze in the middle of B's load-use stall resumes the countdown.
      add("lu_pre_frz", 1'b1, 5'd5, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, O_LU, 0, 0);
      frz("frz_in_lu", 1'b0, 1'b0, O_FRZ, O_FRZ, 0, 0);
      frz("frz_in_lu", 1'b0, 1'b0, O_FRZ, O_FRZ, 0, 0);
      frz("rel_in_lu", 1'b0, 1'b1, O_RUN, O_LU, 0, 0);
      idle("lu_resume_b3", O_RUN, O_LU, 0, 0);
      idle("lu_resume_done", O_RUN, O_RUN, 0, 0);
      // Timeout: B's flag is visible from the 10th MEM_WAIT cycle (11th freeze cycle).
      for (int k = 1; k <= 12; k++)
         frz("timeout", 1'b0, 1'b0, O_FRZ, O_FRZ, 1'b0, (k >= 11));
      frz("timeout_rel", 1'b0, 1'b1, O_RUN, O_RUN, 0, 1);
      idle("timeout_sticky", O_RUN, O_RUN, 0, 1);
      // Reset in the middle of MEM_WAIT.
      frz("frz_pre_rst", 1'b0, 1'b0, O_FRZ, O_FRZ, 0, 1);
      frz("frz_pre_rst", 1'b0, 1'b0, O_FRZ, O_FRZ, 0, 1);
      add("rst_in_wait", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_RST, O_RST, 0, 1);
      idle("post_rst", O_RUN, O_RUN, 0, 0);

      rst_n = 1'b0; if_id_rs1 = 5'd1; if_id_rs2 = 5'd2; if_id_uses_rs2 = 1'b0;
      id_ex_rd = 5'd0; id_ex_memread = 1'b0; ex_branch_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);

      foreach (tbl[i]) begin
         @(posedge clk);
         #1;
         rst_n = tbl[i].r; if_id_rs1 = tbl[i].rs1; if_id_rs2 = tbl[i].rs2;
         if_id_uses_rs2 = tbl[i].uses; id_ex_rd = tbl[i].rd; id_ex_memread = tbl[i].memread;
         ex_branch_taken = tbl[i].br; mem_req = tbl[i].mreq; mem_ready = tbl[i].mrdy;
         e.nm = tbl[i].nm; e.idx = i; e.ea = tbl[i].ea; e.eb = tbl[i].eb;
         e.ta = tbl[i].ta; e.tb = tbl[i].tb;
         sb.push_back(e);
         @(negedge clk);
         if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL scoreboard row %0d: got empty queue required one entry", i);
         end else begin
            e = sb.pop_front();
            check({e.nm, "_a"}, e.idx,
                  {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_flush_a, pipe_adv_a, stall_active_a, mem_timeout_a},
                  {e.ea, e.ta});
            check({e.nm, "_b"}, e.idx,
                  {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_flush_b, pipe_adv_b, stall_active_b, mem_timeout_b},
                  {e.eb, e.tb});
         end
      end

`ifdef HAZARD_PERF_CNT_EN
      check("perf_stall_b_after_rst", 0, 7'(perf_stall_cycles_b != 32'd0), 7'd0);
      check("perf_flush_b_after_rst", 0, 7'(perf_flushes_b != 32'd0), 7'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
